// File: rtl/beta_decode_stage.sv
// ---------------------------------------------------------------------------
// beta_decode_stage
//
// Registered RV32I instruction decode stage. Fetched instructions arrive on a
// valid/ready handshake and are decoded into register indices, a control-unit
// micro-ROM address and a sign-extended immediate. The results go into a
// small output queue (1 or 2 entries) that feeds the control unit / execute
// stage. Legality of funct7/funct3 is checked, and accepted illegal
// instructions are counted in a saturating counter.
//
// Parameters:
//   XLEN      instruction / PC / immediate width (>= 32)
//   OUT_DEPTH output queue entries, 1 or 2
//   M_EXT     1 = OP-major funct7=0x01 (RV32M) is legal
//   CNT_W     illegal-instruction counter width
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-high
//   flush_i        empty the queue and drop this cycle's input
//   valid_i        instr_i / pc_i valid
//   ready_o        stage can accept (queue not full)
//   instr_i        instruction word
//   pc_i           instruction address
//   valid_o        head entry valid
//   ready_i        consumer accepts head
//   pc_o           PC of head entry
//   rs1_o/rs2_o/rd_o  register indices of head entry
//   imm_o          sign-extended immediate
//   fmt_o          0=R 1=I 2=S 3=B 4=U 5=J 6=SYS 7=NONE
//   cu_addr_o      micro-ROM address (9'h1FF for illegal entries)
//   cu_subaddr_o   {instr[29:28], instr[22:20]}
//   illegal_o      head entry is illegal
//   illegal_cnt_o  accepted illegal instructions, saturating
// ---------------------------------------------------------------------------
module beta_decode_stage #(
  parameter int XLEN      = 32,
  parameter int OUT_DEPTH = 2,
  parameter int M_EXT     = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic [8:0]       cu_addr_o,
  output logic [4:0]       cu_subaddr_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [8:0] CU_ILLEGAL = 9'h1FF;
  localparam logic [1:0] DEPTH      = 2'(OUT_DEPTH);
  localparam bit         M_ALLOWED  = (M_EXT != 0);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SYS  = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [8:0]      cu_addr;
    logic [4:0]      cu_subaddr;
    logic            illegal;
  } entry_t;

  // -------------------------------------------------------------------------
  // Decode of the incoming instruction
  // -------------------------------------------------------------------------
  logic [4:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign op     = instr_i[6:2];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  logic [31:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt;

  assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_fmt = {instr_i[31:12], 12'b0};
  assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

  logic                   op_known;
  logic                   fields_ok;
  logic                   f3_forced_zero;
  logic                   alt_bit;
  logic                   dec_illegal;
  fmt_e                   dec_fmt;
  logic [31:0]            dec_imm32;
  logic signed [XLEN-1:0] dec_imm_ext;
  entry_t                 dec;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    op_known       = 1'b1;
    fields_ok      = 1'b1;
    f3_forced_zero = 1'b0;
    alt_bit        = 1'b0;
    dec_fmt        = FMT_NONE;
    dec_imm32      = 32'd0;

    case (op)
      OPC_OP: begin
        dec_fmt   = FMT_R;
        alt_bit   = funct7[5];
        fields_ok = (funct7 == 7'h00)
                  || ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)))
                  || ((funct7 == 7'h01) && M_ALLOWED);
      end
      OPC_OP_IMM: begin
        dec_fmt   = FMT_I;
        dec_imm32 = imm_i_fmt;
        if (funct3 == 3'd1) begin
          fields_ok = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          // Shift-right: funct7[5] selects arithmetic vs logical
          alt_bit   = funct7[5];
          fields_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
      end
      OPC_LOAD: begin
        dec_fmt   = FMT_I;
        dec_imm32 = imm_i_fmt;
      end
      OPC_JALR: begin
        dec_fmt        = FMT_I;
        dec_imm32      = imm_i_fmt;
        f3_forced_zero = 1'b1;
        fields_ok      = (funct3 == 3'd0);
      end
      OPC_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = imm_s_fmt;
      end
      OPC_BRANCH: begin
        dec_fmt   = FMT_B;
        dec_imm32 = imm_b_fmt;
        fields_ok = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt        = FMT_U;
        dec_imm32      = imm_u_fmt;
        f3_forced_zero = 1'b1;
      end
      OPC_JAL: begin
        dec_fmt        = FMT_J;
        dec_imm32      = imm_j_fmt;
        f3_forced_zero = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_fmt   = FMT_SYS;
        dec_imm32 = imm_i_fmt;
      end
      OPC_MISC_MEM: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        op_known = 1'b0;
      end
    endcase

    dec_illegal = (instr_i[1:0] != 2'b11) || !op_known || !fields_ok;

    // Signed source widens with sign extension when XLEN > 32
    dec_imm_ext = $signed(dec_imm32);

    dec            = '0;
    dec.pc         = pc_i;
    dec.rs1        = instr_i[19:15];
    dec.rs2        = instr_i[24:20];
    dec.rd         = instr_i[11:7];
    dec.cu_subaddr = {instr_i[29:28], instr_i[22:20]};
    dec.illegal    = dec_illegal;
    if (dec_illegal) begin
      dec.cu_addr = CU_ILLEGAL;
      dec.fmt     = FMT_NONE;
      dec.imm     = '0;
    end else begin
      dec.cu_addr = {op, (f3_forced_zero ? 3'd0 : funct3), alt_bit};
      dec.fmt     = dec_fmt;
      dec.imm     = dec_imm_ext;
    end
  end

  // -------------------------------------------------------------------------
  // Output queue
  // -------------------------------------------------------------------------
  entry_t            mem [OUT_DEPTH];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [CNT_W-1:0]  ill_cnt;
  logic              push;
  logic              pop;

  function automatic logic ptr_next(input logic p);
    return (OUT_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  // Ready depends only on registered count; ready_i never reaches ready_o,
  // so a full queue cannot push even while it is popping.
  assign ready_o = (count < DEPTH);
  assign valid_o = (count != 2'd0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i && !flush_i;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      ill_cnt <= '0;
      // NOTE: the queue storage is reset because the data outputs are
      // required to read zero after reset; it is only two entries deep.
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Counter intentionally untouched: the dropped input was never accepted
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
        if (dec.illegal && !(&ill_cnt)) begin
          ill_cnt <= ill_cnt + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry drives the outputs; pushes write the tail, so the head stays
  // stable while the consumer stalls.
  entry_t head;
  assign head = mem[rd_ptr];

  assign pc_o          = head.pc;
  assign rs1_o         = head.rs1;
  assign rs2_o         = head.rs2;
  assign rd_o          = head.rd;
  assign imm_o         = head.imm;
  assign fmt_o         = head.fmt;
  assign cu_addr_o     = head.cu_addr;
  assign cu_subaddr_o  = head.cu_subaddr;
  assign illegal_o     = head.illegal;
  assign illegal_cnt_o = ill_cnt;

endmodule

// File: tb/tb_beta_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_beta_decode_stage
//
// Drives two instances (M_EXT=0 and M_EXT=1) with identical stimulus and
// compares both against a queue-based reference model that decodes from the
// instruction-set rules with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_beta_decode_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_MAX = 15;   // CNT_W = 4

  // Opcode numbers, instr[6:2]
  localparam int O_LOAD = 0,  O_MISC = 3,  O_OPIMM = 4,  O_AUIPC = 5,
                 O_STORE = 8, O_OP = 12,   O_LUI = 13,   O_BRANCH = 24,
                 O_JALR = 25, O_JAL = 27,  O_SYSTEM = 28;

  logic clk = 1'b0;
  logic rst_i, flush_i, valid_i, ready_i;
  logic [31:0] instr_i, pc_i;

  logic        ready_a [2];
  logic        valid_a [2];
  logic        ill_a   [2];
  logic [31:0] pc_a    [2];
  logic [31:0] imm_a   [2];
  logic [4:0]  rs1_a   [2];
  logic [4:0]  rs2_a   [2];
  logic [4:0]  rd_a    [2];
  logic [4:0]  sub_a   [2];
  logic [2:0]  fmt_a   [2];
  logic [8:0]  cu_a    [2];
  logic [3:0]  cnt_a   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    beta_decode_stage #(
      .XLEN(32), .OUT_DEPTH(DEPTH), .M_EXT(g), .CNT_W(4)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_a[g]),
      .instr_i(instr_i), .pc_i(pc_i),
      .valid_o(valid_a[g]), .ready_i(ready_i),
      .pc_o(pc_a[g]), .rs1_o(rs1_a[g]), .rs2_o(rs2_a[g]), .rd_o(rd_a[g]),
      .imm_o(imm_a[g]), .fmt_o(fmt_a[g]), .cu_addr_o(cu_a[g]),
      .cu_subaddr_o(sub_a[g]), .illegal_o(ill_a[g]),
      .illegal_cnt_o(cnt_a[g])
    );
  end

  always #5 clk = ~clk;

  // ------------------------------------------------------------------ model
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    bit          ill;
    logic [8:0]  cu;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } dec_t;

  item_t q[$];
  int    mcnt [2];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic dec_t ref_dec(input logic [31:0] ins, input bit m_ext);
    dec_t d;
    int op, f3, f7, imm, fmt, alt;
    bit ok, no_f3;
    op = int'(ins[6:2]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ok = (ins[1:0] == 2'b11);
    imm = 0; fmt = 7; alt = 0; no_f3 = 0;
    case (op)
      O_OP: begin
        fmt = 0; alt = (f7 >> 5) & 1;
        ok &= (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && m_ext);
      end
      O_OPIMM: begin
        fmt = 1; imm = int'($signed(ins[31:20]));
        if (f3 == 1) ok &= (f7 == 0);
        if (f3 == 5) begin ok &= (f7 == 0 || f7 == 32); alt = (f7 >> 5) & 1; end
      end
      O_LOAD:   begin fmt = 1; imm = int'($signed(ins[31:20])); end
      O_JALR:   begin fmt = 1; imm = int'($signed(ins[31:20])); no_f3 = 1; ok &= (f3 == 0); end
      O_STORE:  begin fmt = 2; imm = int'($signed({ins[31:25], ins[11:7]})); end
      O_BRANCH: begin
        fmt = 3; ok &= !(f3 == 2 || f3 == 3);
        imm = 2 * int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]}));
      end
      O_LUI, O_AUIPC: begin fmt = 4; imm = int'({ins[31:12], 12'h000}); no_f3 = 1; end
      O_JAL: begin
        fmt = 5; no_f3 = 1;
        imm = 2 * int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]}));
      end
      O_SYSTEM: begin fmt = 6; imm = int'($signed(ins[31:20])); end
      O_MISC:   begin fmt = 7; end
      default:  ok = 0;
    endcase
    if (ok) begin
      d.ill = 0;
      d.cu  = 9'(op * 16 + (no_f3 ? 0 : f3 * 2) + alt);
      d.fmt = 3'(fmt);
      d.imm = 32'(imm);
    end else begin
      d.ill = 1; d.cu = 9'h1FF; d.fmt = 3'd7; d.imm = 32'd0;
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    dec_t d;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s.valid%0d", tag, g), 32'(valid_a[g]), 32'(q.size() > 0));
      check($sformatf("%s.ready%0d", tag, g), 32'(ready_a[g]), 32'(q.size() < DEPTH));
      check($sformatf("%s.cnt%0d", tag, g), 32'(cnt_a[g]), 32'(mcnt[g]));
      if (q.size() > 0) begin
        d = ref_dec(q[0].ins, bit'(g));
        check($sformatf("%s.pc%0d", tag, g),  pc_a[g], q[0].pc);
        check($sformatf("%s.rs1%0d", tag, g), 32'(rs1_a[g]), 32'(q[0].ins[19:15]));
        check($sformatf("%s.rs2%0d", tag, g), 32'(rs2_a[g]), 32'(q[0].ins[24:20]));
        check($sformatf("%s.rd%0d", tag, g),  32'(rd_a[g]),  32'(q[0].ins[11:7]));
        check($sformatf("%s.sub%0d", tag, g), 32'(sub_a[g]),
              32'({q[0].ins[29:28], q[0].ins[22:20]}));
        check($sformatf("%s.imm%0d", tag, g), imm_a[g], d.imm);
        check($sformatf("%s.fmt%0d", tag, g), 32'(fmt_a[g]), 32'(d.fmt));
        check($sformatf("%s.cu%0d", tag, g),  32'(cu_a[g]), 32'(d.cu));
        check($sformatf("%s.ill%0d", tag, g), 32'(ill_a[g]), 32'(d.ill));
      end
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic rdy, input logic fl, input string tag);
    bit   exp_valid, exp_ready;
    item_t it;
    valid_i = v; instr_i = ins; pc_i = p; ready_i = rdy; flush_i = fl;
    compare_all(tag);
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (v && exp_ready) begin
        it.ins = ins; it.pc = p;
        q.push_back(it);
        for (int g = 0; g < 2; g++)
          if (ref_dec(ins, bit'(g)).ill && mcnt[g] < CNT_MAX) mcnt[g]++;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops [12];
    logic [31:0] w;
    logic [6:0]  f7;
    ops = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27, 5'd28, 5'd10};
    w = $urandom();
    if ($urandom_range(0, 9) == 0) return w;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom());
    endcase
    w[31:25] = f7;
    w[6:0]   = {ops[$urandom_range(0, 11)], 2'b11};
    return w;
  endfunction

  // --------------------------------------------------------------- stimulus
  int sat_before;

  initial begin
    mcnt[0] = 0; mcnt[1] = 0;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    instr_i = 32'h0000_0013; pc_i = 32'h0;

    // Reset held with an active input
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(valid_a[0]), 32'd0);
      check("rst_ready", 32'(ready_a[0]), 32'd1);
      check("rst_cnt",   32'(cnt_a[0]),   32'd0);
      check("rst_imm",   imm_a[0], 32'd0);
      check("rst_cu",    32'(cu_a[0]), 32'd0);
    end
    rst_i = 1'b0;

    // Single-cycle latency
    step(1, 32'h0000_0013, 32'h100, 0, 0, "t1");
    check("t1_valid", 32'(valid_a[0]), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0, "t1p");

    // ADDI / SUB
    step(1, 32'hFFF1_0093, 32'h104, 0, 0, "addi");
    check("addi_rs1", 32'(rs1_a[0]), 32'd2);
    check("addi_rd",  32'(rd_a[0]),  32'd1);
    check("addi_imm", imm_a[0], 32'hFFFF_FFFF);
    check("addi_fmt", 32'(fmt_a[0]), 32'd1);
    check("addi_cu",  32'(cu_a[0]),  32'h040);
    check("addi_ill", 32'(ill_a[0]), 32'd0);
    step(1, 32'h4020_81B3, 32'h108, 1, 0, "sub");
    check("sub_cu",  32'(cu_a[0]),  32'h0C1);
    check("sub_fmt", 32'(fmt_a[0]), 32'd0);
    step(0, 32'h0, 32'h0, 1, 0, "subp");

    // MUL with and without M extension
    step(1, 32'h0220_81B3, 32'h10C, 0, 0, "mul");
    check("mul_ill0", 32'(ill_a[0]), 32'd1);
    check("mul_cu0",  32'(cu_a[0]),  32'h1FF);
    check("mul_cnt0", 32'(cnt_a[0]), 32'd1);
    check("mul_ill1", 32'(ill_a[1]), 32'd0);
    check("mul_cu1",  32'(cu_a[1]),  32'h0C0);
    check("mul_cnt1", 32'(cnt_a[1]), 32'd0);
    step(0, 32'h0, 32'h0, 1, 0, "mulp");

    // JAL / BEQ immediates
    step(1, 32'h0010_00EF, 32'h110, 0, 0, "jal");
    check("jal_imm", imm_a[0], 32'h0000_0800);
    check("jal_cu",  32'(cu_a[0]),  32'h1B0);
    check("jal_fmt", 32'(fmt_a[0]), 32'd5);
    step(1, 32'hFE00_0EE3, 32'h114, 1, 0, "beq");
    check("beq_imm", imm_a[0], 32'hFFFF_FFFC);
    check("beq_cu",  32'(cu_a[0]),  32'h180);
    check("beq_fmt", 32'(fmt_a[0]), 32'd3);
    step(0, 32'h0, 32'h0, 1, 0, "beqp");

    // Backpressure: A, B fill the queue, C is held off
    step(1, 32'h0010_0093, 32'hA00, 0, 0, "bpA");
    check("bpA_ready", 32'(ready_a[0]), 32'd1);
    step(1, 32'h0020_0093, 32'hB00, 0, 0, "bpB");
    check("bpB_ready", 32'(ready_a[0]), 32'd0);
    step(1, 32'h0030_0093, 32'hC00, 0, 0, "bpC0");
    check("bpC_held_pc", pc_a[0], 32'hA00);
    step(1, 32'h0030_0093, 32'hC00, 1, 0, "bpPopA");
    check("bp_ready_after_pop", 32'(ready_a[0]), 32'd1);
    check("bp_headB", pc_a[0], 32'hB00);
    step(1, 32'h0030_0093, 32'hC00, 0, 0, "bpPushC");
    step(0, 32'h0, 32'h0, 1, 0, "bpPopB");
    check("bp_headC", pc_a[0], 32'hC00);
    step(0, 32'h0, 32'h0, 1, 0, "bpPopC");
    check("bp_empty", 32'(valid_a[0]), 32'd0);

    // Flush of a full queue with a live illegal input
    step(1, 32'h0000_0000, 32'hD00, 0, 0, "flA");
    step(1, 32'h0040_0093, 32'hD04, 0, 0, "flB");
    sat_before = mcnt[0];
    step(1, 32'h0000_0000, 32'hD08, 1, 1, "flush");
    check("fl_valid", 32'(valid_a[0]), 32'd0);
    check("fl_ready", 32'(ready_a[0]), 32'd1);
    check("fl_cnt",   32'(cnt_a[0]),   32'(sat_before));
    step(1, 32'h0050_0093, 32'hD0C, 0, 0, "fl2A");
    step(1, 32'h0000_0000, 32'hD10, 0, 1, "flush2");
    check("fl2_valid", 32'(valid_a[0]), 32'd0);
    check("fl2_cnt",   32'(cnt_a[0]),   32'(sat_before));

    // Drive the counter into saturation
    for (int i = 0; i < 20; i++)
      step(1, 32'hFFFF_FFF0 | 32'(i), 32'(i * 4), 1, 0, "sat");
    check("sat_cnt0", 32'(cnt_a[0]), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, "rnd");

    // Asynchronous reset between clock edges with entries queued
    step(1, 32'h0000_0013, 32'hE00, 0, 0, "arA");
    step(1, 32'h0000_0013, 32'hE04, 0, 0, "arB");
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 32'(valid_a[0]), 32'd0);
    check("arst_ready", 32'(ready_a[0]), 32'd1);
    check("arst_cnt",   32'(cnt_a[1]),   32'd0);
    q.delete(); mcnt[0] = 0; mcnt[1] = 0;
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 1) != 0, 0, "post");
    compare_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
